down_timer: RTL and testbench
=============================

DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter WIDTH, default 4, is the counter width in bits (legal range 2..16).
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ld  input  1  load strobe; captures ldvalue as count and reload value.
REQ-005 ldvalue  input  WIDTH  load/reload value.
REQ-006 en  input  1  count enable; decrement permitted only when high.
REQ-007 auto_reload  input  1  when high at terminal count, restart from the stored reload value.
REQ-008 dout  output  WIDTH  current count, registered.
REQ-009 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  high while in DONE.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-013 Priority on each edge SHALL be rst > ld > en.
REQ-014 On ld with ldvalue != 0, from any state, the next-cycle values SHALL be dout=ldvalue, reload register=ldvalue, state=RUN, tc=0.
REQ-015 On ld with ldvalue == 0, from any state, the next-cycle values SHALL be dout=0, reload register=0, state=DONE, tc=0.
REQ-016 In RUN with en=1, ld=0 and dout>1, dout SHALL decrement by 1 per cycle, with a latency of one clock.
REQ-017 In RUN with en=1, ld=0 and dout==1 (terminal event), tc SHALL be 1 in the next cycle.
REQ-018 At a terminal event with auto_reload=0, the next cycle SHALL have dout=0 and state=DONE.
REQ-019 At a terminal event with auto_reload=1, the next cycle SHALL have dout=reload register and state=RUN, so the period is the reload value in enabled cycles.
REQ-020 tc SHALL be 0 in every cycle not following a terminal event.
REQ-021 In RUN with en=0, dout and state SHALL hold.
REQ-022 In IDLE and DONE, dout SHALL hold and en SHALL be ignored.
REQ-023 DONE SHALL persist until ld or rst.
REQ-024 busy SHALL equal (state==RUN) and done SHALL equal (state==DONE), both decoded from registered state.
REQ-025 Decrement arithmetic SHALL be unsigned modulo 2^WIDTH.
REQ-026 Decrement SHALL never wrap below 0, because the terminal event intercepts dout==1.
REQ-027 ldvalue = 2^WIDTH-1 SHALL be accepted, giving a full-range period.
REQ-028 ld asserted in the same cycle as a terminal event SHALL win: tc stays 0 and the new ldvalue is loaded.
REQ-029 auto_reload SHALL be sampled only at the terminal event; changes at other times have no effect.

Reset
REQ-030 When rst=1 at a rising clk edge, the next cycle SHALL have state=IDLE, dout=0, reload register=0, tc=0, busy=0 and done=0.
REQ-031 Reset asserted mid-count, including in the terminal-event cycle, SHALL abort the count with no tc pulse.
REQ-032 After reset deasserts, the block SHALL remain in IDLE until ld.
REQ-033 An initial block SHALL give the registers the same values as reset, for simulation.

Structure
REQ-034 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL be defined as constants in the shared package down_timer_pkg.
REQ-035 The default WIDTH SHALL also be defined in down_timer_pkg.
REQ-036 The block SHALL be a single module with no sub-module, since the datapath is one register plus one decrementer.
REQ-037 All outputs SHALL be driven from flops or from state-only decode; there SHALL be no combinational input-to-output path.

Verification (WIDTH=4)
REQ-038 Load and count: rst, then ld with ldvalue=3, en=1, auto_reload=0 -> dout 3,2,1,0; tc=1 in the cycle dout=0; done=1 from that cycle and held.
REQ-039 Auto-reload: ld with ldvalue=2, en=1, auto_reload=1 -> dout 2,1,2,1,2; tc every 2nd cycle, on each reload; busy constantly 1.
REQ-040 Enable gating: ld with ldvalue=5, en toggled 1,0,0,1 -> dout 5,4,4,4,3.
REQ-041 Collision: ld with ldvalue=9 in the cycle dout==1 with en=1 -> next cycle dout=9, tc=0, state RUN.
REQ-042 Reset mid-operation: rst in the terminal-event cycle -> next cycle dout=0, tc=0, IDLE; no tc afterwards.
REQ-043 Edge values: ld with ldvalue=0 -> done=1 next cycle and tc never asserted; ld with ldvalue=15 -> 15 enabled cycles to tc.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared constants for the down_timer block: FSM state encodings and default width.
package down_timer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter with a terminal-count pulse and optional auto-reload.
// All outputs come straight from flops or from the registered state.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] ldvalue,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] dout,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    // Declaration initialisers match the reset values so simulation starts in IDLE.
    logic [1:0]       state  = IDLE;
    logic [WIDTH-1:0] count  = '0;
    logic [WIDTH-1:0] reload = '0;
    logic             tc_q   = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            tc_q   <= 1'b0;
        end else if (ld) begin
            count  <= ldvalue;
            reload <= ldvalue;
            state  <= (ldvalue != '0) ? RUN : DONE;
            tc_q   <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            case (state)
                RUN: begin
                    if (en) begin
                        // Terminal event intercepts count==1, so the decrement never wraps.
                        if (count == WIDTH'(1)) begin
                            tc_q <= 1'b1;
                            if (auto_reload) begin
                                count <= reload;
                            end else begin
                                count <= '0;
                                state <= DONE;
                            end
                        end else begin
                            count <= count - WIDTH'(1);
                        end
                    end
                end
                IDLE, DONE: begin
                    state <= state;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign dout = count;
    assign tc   = tc_q;
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: a behavioural model predicts each cycle's outputs,
// directed scenarios add hand-derived constants, then a random phase exercises the rest.
module tb_down_timer;
    import down_timer_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ld = 1'b0;
    logic [W-1:0] ldvalue = '0;
    logic         en = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] dout;
    logic         tc, busy, done;

    always #5 clk = ~clk;

    down_timer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ld(ld), .ldvalue(ldvalue), .en(en),
        .auto_reload(auto_reload), .dout(dout), .tc(tc), .busy(busy), .done(done)
    );

    typedef struct {
        logic [W-1:0] dout;
        logic         tc;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    logic [1:0]   m_state = IDLE;
    logic [W-1:0] m_count = '0;
    logic [W-1:0] m_reload = '0;
    logic         m_tc = 1'b0;

    logic [W-1:0] obs_dout;
    logic         obs_tc, obs_busy, obs_done;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Behavioural reference: rst beats ld beats en; only RUN counts.
    task automatic modelStep(input logic r, input logic l, input logic [W-1:0] v, input logic e, input logic a);
        m_tc = 1'b0;
        if (r) begin
            m_state = IDLE; m_count = '0; m_reload = '0;
        end else if (l) begin
            m_count = v; m_reload = v;
            m_state = (v == 0) ? DONE : RUN;
        end else if (m_state == RUN && e) begin
            if (m_count == 1) begin
                m_tc = 1'b1;
                if (a) m_count = m_reload;
                else begin m_count = 0; m_state = DONE; end
            end else begin
                m_count = m_count - 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic [W-1:0] v, input logic e, input logic a);
        exp_t ex;
        exp_t got;
        @(negedge clk);
        rst = r; ld = l; ldvalue = v; en = e; auto_reload = a;
        modelStep(r, l, v, e, a);
        ex.dout = m_count;
        ex.tc   = m_tc;
        ex.busy = (m_state == RUN);
        ex.done = (m_state == DONE);
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        obs_dout = dout; obs_tc = tc; obs_busy = busy; obs_done = done;
        got = exp_q.pop_front();
        checkOutput("sb_dout", {28'd0, obs_dout}, {28'd0, got.dout});
        checkOutput("sb_tc",   {31'd0, obs_tc},   {31'd0, got.tc});
        checkOutput("sb_busy", {31'd0, obs_busy}, {31'd0, got.busy});
        checkOutput("sb_done", {31'd0, obs_done}, {31'd0, got.done});
    endtask

    task automatic expectObs(input string tag, input int d, input int t, input int b, input int dn);
        checkOutput({tag, "_dout"}, {28'd0, obs_dout}, d);
        checkOutput({tag, "_tc"},   {31'd0, obs_tc},   t);
        checkOutput({tag, "_busy"}, {31'd0, obs_busy}, b);
        checkOutput({tag, "_done"}, {31'd0, obs_done}, dn);
    endtask

    initial begin
        // Reset, then stay IDLE with en high and no load.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0);
        expectObs("reset", 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        expectObs("idle_hold", 0, 0, 0, 0);

        // Load 3, count to zero, DONE persists.
        applyStimulus(0, 1, 3, 1, 0); expectObs("ld3_a", 3, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); expectObs("ld3_b", 2, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); expectObs("ld3_c", 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); expectObs("ld3_d", 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 0); expectObs("ld3_e", 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1); expectObs("ld3_f", 0, 0, 0, 1);

        // Auto-reload with period 2.
        applyStimulus(0, 1, 2, 1, 1); expectObs("ar_a", 2, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1); expectObs("ar_b", 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1); expectObs("ar_c", 2, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); expectObs("ar_d", 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1); expectObs("ar_e", 2, 1, 1, 0);

        // Enable gating.
        applyStimulus(0, 1, 5, 1, 0); expectObs("en_a", 5, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); expectObs("en_b", 4, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0); expectObs("en_c", 4, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0); expectObs("en_d", 4, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); expectObs("en_e", 3, 0, 1, 0);

        // Load collides with the terminal event.
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); expectObs("col_pre", 1, 0, 1, 0);
        applyStimulus(0, 1, 9, 1, 0); expectObs("col", 9, 0, 1, 0);

        // Reset in the terminal-event cycle.
        applyStimulus(0, 1, 1, 1, 0); expectObs("rstmid_pre", 1, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 1); expectObs("rstmid", 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1); expectObs("rstmid_post", 0, 0, 0, 0);

        // Load of zero goes straight to DONE without a pulse.
        applyStimulus(0, 1, 0, 1, 0); expectObs("ld0_a", 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1); expectObs("ld0_b", 0, 0, 0, 1);

        // Full-range load: tc after exactly 15 enabled cycles.
        applyStimulus(0, 1, 15, 1, 0); expectObs("ld15_ld", 15, 0, 1, 0);
        for (int k = 1; k <= 14; k++) begin
            applyStimulus(0, 0, 0, 1, 0);
            checkOutput("ld15_tc_low", {31'd0, obs_tc}, 0);
            checkOutput("ld15_cnt", {28'd0, obs_dout}, 15 - k);
        end
        applyStimulus(0, 0, 0, 1, 0); expectObs("ld15_end", 0, 1, 0, 1);

        // Random phase against the model.
        for (int i = 0; i < 400; i++) begin
            logic r, l, e, a;
            logic [W-1:0] v;
            r = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 7) == 0);
            v = W'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) v = W'($urandom_range(0, 2));
            e = ($urandom_range(0, 3) != 0);
            a = $urandom_range(0, 1) == 1;
            applyStimulus(r, l, v, e, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
